// File: rtl/fp_mult_share_arb_pkg.sv
// Shared types and constants for the shared FP multiplier: mode encoding,
// exponent constants, flag bit positions and the approximate-mode operand masks.
package fp_mult_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_TRUNC = 2'd1,
        MODE_DRUM  = 2'd2,
        MODE_FOIL  = 2'd3
    } mode_e;

    localparam int         EXP_BIAS = 127;
    localparam logic [7:0] EXP_MAX  = 8'hFF;

    localparam int FLG_EXC = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UNF = 0;

    // Truncated mode keeps the top 12 mantissa bits; DRUM keeps the top 8 and
    // forces the lowest kept bit to 1 to centre the truncation error.
    localparam logic [23:0] TRUNC_MASK = 24'hFFF000;
    localparam logic [23:0] DRUM_MASK  = 24'hFF0000;
    localparam logic [23:0] DRUM_LSB   = 24'h010000;

endpackage

// File: rtl/fp_mult_share_arb_core.sv
// Combinational single-precision multiplier with four mantissa units
// (exact, truncated, DRUM, FOIL) and a mode mux feeding one exponent/flag path.
module fp_mult_core
    import fp_mult_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  mode_e       i_mode,
    output logic [31:0] o_result,
    output logic [2:0]  o_flags
);

    logic [7:0]  w_ea, w_eb;
    logic [23:0] w_ma, w_mb;
    logic [23:0] w_ma_trunc, w_mb_trunc, w_ma_drum, w_mb_drum;
    logic [47:0] w_p_exact, w_p_trunc, w_p_drum, w_p_foil, w_p;
    logic        w_norm;
    logic [22:0] w_mant;
    logic [8:0]  w_exp9;
    logic        w_sign, w_exc, w_zero, w_ovf, w_unf;
    logic        w_unused_lsbs;

    assign w_ea   = i_a[30:23];
    assign w_eb   = i_b[30:23];
    assign w_ma   = {|w_ea, i_a[22:0]};
    assign w_mb   = {|w_eb, i_b[22:0]};
    assign w_sign = i_a[31] ^ i_b[31];

    assign w_ma_trunc = w_ma & TRUNC_MASK;
    assign w_mb_trunc = w_mb & TRUNC_MASK;
    assign w_ma_drum  = (w_ma & DRUM_MASK) | DRUM_LSB;
    assign w_mb_drum  = (w_mb & DRUM_MASK) | DRUM_LSB;

    assign w_p_exact = 48'(w_ma) * 48'(w_mb);
    assign w_p_trunc = 48'(w_ma_trunc) * 48'(w_mb_trunc);
    assign w_p_drum  = 48'(w_ma_drum) * 48'(w_mb_drum);
    // FOIL drops the low x low partial product, keeping the three upper terms.
    assign w_p_foil  = ((48'(w_ma[23:12]) * 48'(w_mb[23:12])) << 24)
                     + ((48'(w_ma[23:12]) * 48'(w_mb[11:0])
                       + 48'(w_ma[11:0]) * 48'(w_mb[23:12])) << 12);

    always_comb begin
        w_p = w_p_exact;
        case (i_mode)
            MODE_TRUNC: w_p = w_p_trunc;
            MODE_DRUM:  w_p = w_p_drum;
            MODE_FOIL:  w_p = w_p_foil;
            default:    w_p = w_p_exact;
        endcase
    end

    assign w_norm        = w_p[47];
    assign w_mant        = w_norm ? w_p[46:24] : w_p[45:23];
    assign w_unused_lsbs = ^w_p[22:0];

    assign w_exp9 = 9'(w_ea) + 9'(w_eb) - 9'(EXP_BIAS) + 9'(w_norm);
    assign w_exc  = (w_ea == EXP_MAX) | (w_eb == EXP_MAX);
    assign w_zero = (i_a[30:0] == 31'd0) | (i_b[30:0] == 31'd0);
    assign w_ovf  = w_exp9[8] & ~w_exp9[7];
    assign w_unf  = w_exp9[8] & w_exp9[7];

    always_comb begin
        o_result = {w_sign, w_exp9[7:0], w_mant};
        o_flags  = 3'b000;
        if (w_exc) begin
            o_result         = 32'd0;
            o_flags[FLG_EXC] = 1'b1;
        end else if (w_zero) begin
            o_result = {w_sign, 31'd0};
        end else if (w_ovf) begin
            o_result         = {w_sign, EXP_MAX, 23'd0};
            o_flags[FLG_OVF] = 1'b1;
        end else if (w_unf) begin
            o_result         = {w_sign, 31'd0};
            o_flags[FLG_UNF] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mult_share_arb.sv
// Round-robin front end sharing one FP multiplier among NREQ requesters through
// a two-stage pipeline (operand capture, registered result) with valid/ready backpressure.
module fp_mult_share_arb
    import fp_mult_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*2-1:0]    req_mode,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic [2:0]           rsp_flags
);

    logic [IDW-1:0]  r_ptr;
    logic            r_s1_valid;
    logic [31:0]     r_s1_a, r_s1_b;
    mode_e           r_s1_mode;
    logic [IDW-1:0]  r_s1_id;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [31:0]     r_rsp_result;
    logic [2:0]      r_rsp_flags;

    logic [NREQ-1:0] w_hi, w_pool, w_grant;
    logic [IDW-1:0]  w_gnt_id, w_ptr_next;
    logic [31:0]     w_sel_a, w_sel_b;
    logic [1:0]      w_sel_mode;
    logic            w_s1_en, w_s2_en, w_accept;
    logic [31:0]     w_core_result;
    logic [2:0]      w_core_flags;

    // Round robin: prefer requesters at or above ptr, else wrap to the lowest.
    always_comb begin
        w_hi = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_hi[j] = req_valid[j] & (IDW'(j) >= r_ptr);
        end
        w_pool     = (|w_hi) ? w_hi : req_valid;
        w_grant    = '0;
        w_gnt_id   = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_mode = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_pool[j]) begin
                w_grant    = '0;
                w_grant[j] = 1'b1;
                w_gnt_id   = IDW'(j);
                w_sel_a    = req_a[j*32 +: 32];
                w_sel_b    = req_b[j*32 +: 32];
                w_sel_mode = req_mode[j*2 +: 2];
            end
        end
    end

    assign w_s2_en    = ~r_rsp_valid | rsp_ready;
    assign w_s1_en    = ~r_s1_valid | w_s2_en;
    assign req_ready  = w_grant & {NREQ{w_s1_en & rst_n}};
    assign w_accept   = |req_ready;
    assign w_ptr_next = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

    fp_mult_core u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_mode   (r_s1_mode),
        .o_result (w_core_result),
        .o_flags  (w_core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_mode    <= MODE_EXACT;
            r_s1_id      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
            if (w_s1_en) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_a    <= w_sel_a;
                    r_s1_b    <= w_sel_b;
                    r_s1_mode <= mode_e'(w_sel_mode);
                    r_s1_id   <= w_gnt_id;
                end
            end
            if (w_s2_en) begin
                r_rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rsp_id     <= r_s1_id;
                    r_rsp_result <= w_core_result;
                    r_rsp_flags  <= w_core_flags;
                end
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_fp_mult_share_arb.sv
// Randomised bench for fp_mult_share_arb: a transaction-level scoreboard with an
// arithmetic multiplier model, a round-robin grant model and directed corner cases.
module tb_fp_mult_share_arb;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      reqValid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*32-1:0]   reqA, reqB;
   logic [NREQ*2-1:0]    reqMode;
   logic                 rsp_valid;
   logic                 rspReady;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_result;
   logic [2:0]           rsp_flags;

   int errCount = 0;
   int checkCount = 0;
   logic [IDW+34:0] expQ[$];
   int mPtr = 0;
   int autoRefill = 0;
   int validPct = 100;
   logic lastRspValid;
   logic [IDW+34:0] lastRsp;
   int lastAccId;

   fp_mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (reqValid),
      .req_ready  (req_ready),
      .req_a      (reqA),
      .req_b      (reqB),
      .req_mode   (reqMode),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rspReady),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_flags  (rsp_flags)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Every comparison in the bench passes through here
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Arithmetic model of the multiplier, returns {flags, result}
   function automatic logic [34:0] refMult(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
      int ea, eb, e, norm;
      longint ma, mb, p, ah, al, bh, bl;
      logic sign;
      logic [22:0] mant;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      sign = a[31] ^ b[31];
      if (ea == 255 || eb == 255) return {3'b100, 32'h0};
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {3'b000, sign, 31'h0};
      ma = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
      mb = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
      case (mode)
         2'd0: p = ma * mb;
         2'd1: p = ((ma / 4096) * 4096) * ((mb / 4096) * 4096);
         2'd2: p = (((ma / 65536) | 1) * 65536) * (((mb / 65536) | 1) * 65536);
         default: begin
            ah = ma / 4096; al = ma % 4096;
            bh = mb / 4096; bl = mb % 4096;
            p = ah * bh * 64'd16777216 + (ah * bl + al * bh) * 64'd4096;
         end
      endcase
      norm = (p >= 64'd140737488355328) ? 1 : 0;
      mant = 23'((p >> (23 + norm)) % 64'd8388608);
      e = ea + eb - 127 + norm;
      if (e > 255) return {3'b010, sign, 8'hFF, 23'h0};
      if (e < 0) return {3'b001, sign, 31'h0};
      return {3'b000, sign, 8'(e), mant};
   endfunction

   // Grant rule: first valid requester from mPtr upward, wrapping
   function automatic int modelGrant(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(mPtr + k) % NREQ]) return (mPtr + k) % NREQ;
      end
      return -1;
   endfunction

   // Operands biased towards exception, zero, denormal, overflow and underflow ranges
   function automatic logic [31:0] randOperand();
      logic [7:0] e;
      int r;
      r = $urandom_range(0, 9);
      case (r)
         0: e = 8'hFF;
         1: e = 8'h00;
         2: e = 8'($urandom_range(1, 20));
         3: e = 8'($urandom_range(235, 254));
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom)};
   endfunction

   task automatic loadOperand(input int i);
      reqA[i*32 +: 32] = randOperand();
      reqB[i*32 +: 32] = randOperand();
      reqMode[i*2 +: 2] = 2'($urandom);
   endtask

   // One clock: check at negedge against the model, then advance the model after posedge
   task automatic stepCycle();
      int g;
      logic [NREQ-1:0] expReady;
      logic canAccept, rspTaken;
      @(negedge clk);
      g = modelGrant(reqValid);
      canAccept = !(expQ.size() >= 2 && !rspReady);
      expReady = '0;
      if (g >= 0 && canAccept) expReady[g] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      lastRspValid = rsp_valid;
      lastRsp = {rsp_id, rsp_flags, rsp_result};
      if (rsp_valid) begin
         if (expQ.size() == 0) checkOutput("rsp_valid_empty", 64'(rsp_valid), 64'd0);
         else checkOutput("rsp", 64'({rsp_id, rsp_flags, rsp_result}), 64'(expQ[0]));
      end
      rspTaken = rsp_valid && rspReady;
      @(posedge clk);
      #1;
      if (rspTaken && expQ.size() > 0) void'(expQ.pop_front());
      lastAccId = -1;
      if (expReady != '0) begin
         expQ.push_back({IDW'(g), refMult(reqA[g*32 +: 32], reqB[g*32 +: 32], reqMode[g*2 +: 2])});
         mPtr = (g + 1) % NREQ;
         lastAccId = g;
         reqValid[g] = (autoRefill != 0) && ($urandom_range(1, 100) <= validPct);
         if (reqValid[g]) loadOperand(g);
      end
      if (autoRefill != 0) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!reqValid[i] && $urandom_range(1, 100) <= validPct) begin
               reqValid[i] = 1'b1;
               loadOperand(i);
            end
         end
      end
   endtask

   // Present one request on requester r and wait (bounded) for it to be accepted
   task automatic applyStimulus(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode);
      int n;
      reqValid[r] = 1'b1;
      reqA[r*32 +: 32] = a;
      reqB[r*32 +: 32] = b;
      reqMode[r*2 +: 2] = mode;
      n = 0;
      do begin
         stepCycle();
         n++;
      end while (lastAccId != r && n < 10);
      if (lastAccId != r) checkOutput("accept_timeout", 64'(lastAccId), 64'(r));
   endtask

   // Single transaction with a hand-derived expected result and exact 2-cycle latency
   task automatic directedOp(input int r, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expRes, input logic [2:0] expFlg);
      applyStimulus(r, a, b, 2'd0);
      stepCycle();
      checkOutput("lat1_valid", 64'(lastRspValid), 64'd0);
      stepCycle();
      checkOutput("lat2_valid", 64'(lastRspValid), 64'd1);
      checkOutput("dir_id", 64'(lastRsp[IDW+34:35]), 64'(r));
      checkOutput("dir_result", 64'(lastRsp[31:0]), 64'(expRes));
      checkOutput("dir_flags", 64'(lastRsp[34:32]), 64'(expFlg));
   endtask

   task automatic drainPipe(input string tag);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 20) begin
         stepCycle();
         n++;
      end
      checkOutput(tag, 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      int rrExp;
      logic [IDW+34:0] heldRsp;
      int n;

      // Reset with requests already pending: nothing may be granted or emitted
      rst_n = 1'b0;
      rspReady = 1'b1;
      reqValid = '1;
      for (int i = 0; i < NREQ; i++) loadOperand(i);
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
      checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
      checkOutput("reset_rsp_result", 64'(rsp_result), 64'd0);
      checkOutput("reset_rsp_flags", 64'(rsp_flags), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reqValid = '0;
      mPtr = 0;

      // Directed arithmetic corners
      autoRefill = 0;
      directedOp(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
      directedOp(0, 32'h7F800000, 32'h40000000, 32'h00000000, 3'b100);
      directedOp(1, 32'h00000000, 32'h40000000, 32'h00000000, 3'b000);
      directedOp(2, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010);
      directedOp(3, 32'h00800000, 32'h00800000, 32'h00000000, 3'b001);
      directedOp(0, 32'hBF800000, 32'h3F800000, 32'hBF800000, 3'b000);

      // All requesters continuously valid: strict rotation, one response per cycle
      autoRefill = 1;
      validPct = 100;
      rspReady = 1'b1;
      reqValid = '1;
      for (int i = 0; i < NREQ; i++) loadOperand(i);
      rrExp = mPtr;
      for (int c = 0; c < 14; c++) begin
         stepCycle();
         checkOutput("rr_order", 64'(lastAccId), 64'(rrExp));
         rrExp = (rrExp + 1) % NREQ;
         if (c >= 2) checkOutput("throughput", 64'(lastRspValid), 64'd1);
      end

      // Sink stall: response must hold steady, then resume in order
      rspReady = 1'b0;
      stepCycle();
      heldRsp = lastRsp;
      for (int c = 0; c < 4; c++) begin
         stepCycle();
         checkOutput("s2_hold", 64'(lastRsp), 64'(heldRsp));
      end
      rspReady = 1'b1;
      repeat (6) stepCycle();

      // Same operands in all four modes back-to-back
      autoRefill = 0;
      reqValid = '0;
      drainPipe("drain_before_modes");
      for (int i = 0; i < NREQ; i++) begin
         reqA[i*32 +: 32] = 32'h3FAAAAAB;
         reqB[i*32 +: 32] = 32'h3FAAAAAB;
         reqMode[i*2 +: 2] = 2'(i);
      end
      reqValid = '1;
      repeat (2) stepCycle();
      drainPipe("drain_modes");

      // Reset while both stages hold data
      autoRefill = 1;
      validPct = 100;
      rspReady = 1'b0;
      n = 0;
      while (expQ.size() < 2 && n < 8) begin
         stepCycle();
         n++;
      end
      checkOutput("fill_before_reset", 64'(expQ.size()), 64'd2);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
      expQ.delete();
      mPtr = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rspReady = 1'b1;
      reqValid = '1;
      stepCycle();
      checkOutput("post_rst_grant", 64'(lastAccId), 64'd0);

      // Random traffic with random backpressure
      validPct = 60;
      for (int c = 0; c < 400; c++) begin
         rspReady = ($urandom_range(0, 3) != 0);
         stepCycle();
      end

      autoRefill = 0;
      reqValid = '0;
      rspReady = 1'b1;
      drainPipe("final_drain");

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
